uart_rx: RTL and testbench
==========================

# uart_rx

Receive half of the UART link: recovers frames produced by the team's UART transmitter. A frame is 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits) and 1 stop bit (1). Serial input is synchronised, start-validated and mid-bit sampled using a 16x oversampling strobe from the shared baud generator. Each received byte is presented with a one-cycle valid pulse and error flags to the downstream consumer, for example a FIFO or register bank.

## Interface
- OVERSAMPLE, 16: `rx_tick` strobes per bit period. Must be a power of two, at least 8.
- DATA_BITS, 8: data bits per frame. The parity bit is always appended.

- clock  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- rx  in  1  asynchronous serial line; idles high
- rx_tick  in  1  one-clock strobe at OVERSAMPLE x baud
- data_out  out  DATA_BITS  last received byte; held until the next frame completes
- rx_valid  out  1  one-clock pulse when a frame completes
- parity_err  out  1  parity mismatch on the last frame; updated with `rx_valid`
- frame_err  out  1  stop bit sampled 0 on the last frame; updated with `rx_valid`
- rx_busy  out  1  high in any state other than IDLE

## Operation
- `rx` passes through a 2-FF synchroniser with reset value 1. All logic uses the synchronised copy, `rx_s`.
- Counters:
  - tick counter: log2(OVERSAMPLE) bits, wraps naturally
  - bit counter: 4 bits
  - shift register: DATA_BITS+1 bits, shifts right, new bit enters at the MSB
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - On `rx_tick` with `rx_s`=0, go to START and clear the tick counter.
- START:
  - Each `rx_tick` increments the tick counter.
  - On the tick where the counter reaches OVERSAMPLE/2-1, sample `rx_s`.
  - If 0: go to DATA and clear the tick and bit counters.
  - If 1: false start. Return to IDLE with no output change.
- DATA:
  - Each `rx_tick` increments the tick counter.
  - On the tick where the counter reaches OVERSAMPLE-1, shift `rx_s` into the shift register and increment the bit counter.
  - After the DATA_BITS+1th sample (data plus parity), go to STOP and clear the tick counter.
- STOP:
  - On the tick where the counter reaches OVERSAMPLE-1, sample `rx_s` and perform all of the following:
    - load `data_out` with shift[DATA_BITS-1:0]
    - set `parity_err` = (^shift[DATA_BITS-1:0]) != shift[DATA_BITS]
    - set `frame_err` = !`rx_s`
    - pulse `rx_valid`
    - go to IDLE
- A frame with errors still delivers `data_out` and `rx_valid`. The consumer decides whether to drop it.
- Without `rx_tick`, no state or counter changes, except that the synchroniser keeps running.
- Unused state encodings go to IDLE.

## Timing
- Reset values: state IDLE; all counters 0; shift register 0; `data_out` 0; `rx_valid` 0; `parity_err` 0; `frame_err` 0; `rx_busy` 0; synchroniser 1.
- Reset asserted mid-frame aborts at once. No `rx_valid` is produced for the aborted frame.
- `rx_valid` is registered. It is high for exactly one clock, the cycle after the STOP sampling tick.
  - `data_out`, `parity_err` and `frame_err` change on that same edge and are stable while `rx_valid` is high.
- Latency from the line falling edge to `rx_valid`: 2 clocks of synchroniser plus about (DATA_BITS+2.5) x OVERSAMPLE ticks, then 1 clock.
- Back-to-back frames are supported:
  - IDLE is re-entered mid stop bit.
  - A start edge at the earliest 1/2 bit later is detected.
  - No dead time beyond that is required.
- A stop bit sampled 0 (break or framing error) goes to IDLE. Because `rx_s` is still low, START is re-entered on the next tick. This is the required behaviour.

## Structure
- Shared UART package holds:
  - state encodings: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11, matching the transmitter
  - default OVERSAMPLE and DATA_BITS constants
  - even-parity definition
- One sub-module: `uart_sync2`, a generic 2-FF synchroniser with a reset-value parameter, reusable for other async inputs.
- FSM, counters and output registers stay in `uart_rx`.

## Test plan
- 0xA5 frame (parity 0, stop 1) at OVERSAMPLE=16 -> one `rx_valid`; `data_out`=0xA5; `parity_err`=0; `frame_err`=0.
- 0x01 frame sent with parity bit 0 -> `rx_valid`; `data_out`=0x01; `parity_err`=1; `frame_err`=0.
- 0x3C frame with stop bit 0 -> `data_out`=0x3C, `frame_err`=1. Then line held high and frame 0x55 sent -> `data_out`=0x55, both errors 0.
- Line low for 4 ticks then high (glitch) -> `rx_busy` pulses; no `rx_valid`; `data_out` unchanged.
- Frames 0x00, 0xFF, 0x80 sent back-to-back with 1-bit stop -> exactly three `rx_valid` pulses, values in order, no errors.
- `reset_n` low for 1 clock during bit 4 of a frame -> all outputs at reset values; no `rx_valid` for that frame; the next full frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions used by the transmitter and the receiver:
//   - uart_state_e : FSM state encodings (identical in TX and RX)
//   - DEFAULT_OVERSAMPLE / DEFAULT_DATA_BITS : default frame parameters
//   - even_parity() : parity bit carried in every frame
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DATA_BITS  = 8;

  // Even parity: the parity bit equals the XOR of the data bits. Callers
  // zero-extend their data word to 32 bits, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Generic two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops load RESET_VAL
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clocks of latency
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 even-parity
// bit, 1 stop bit. The line is sampled mid-bit using an OVERSAMPLE x baud
// strobe. Every completed frame is delivered, errors are only flagged.
// Ports:
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   rx_i         : asynchronous serial line, idles high
//   rx_tick_i    : one-clock strobe at OVERSAMPLE x baud
//   data_out_o   : last received data word, held until the next frame
//   rx_valid_o   : one-clock pulse when a frame completes
//   parity_err_o : parity mismatch on the last frame
//   frame_err_o  : stop bit sampled low on the last frame
//   rx_busy_o    : receiver is not idle
// DATA_BITS must be at most 14 so that data plus parity fit the 4-bit
// bit counter; OVERSAMPLE must be a power of two, at least 8.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic                 rx_tick_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 rx_busy_o
);

  localparam int unsigned    TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TICK_ONE = TW'(1);
  localparam logic [TW-1:0]  TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  TICK_END = TW'(OVERSAMPLE - 1);
  // Index of the parity sample, the last one taken in DATA.
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [TW-1:0]        tick_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS:0]   shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  logic [DATA_BITS:0]   shift_d;
  logic                 parity_err_d;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  // Bits arrive LSB first, so they enter at the MSB and shift down; after
  // data plus parity the parity bit sits at the top of the register.
  assign shift_d      = {rx_s, shift_q[DATA_BITS:1]};
  assign parity_err_d = even_parity(32'(shift_q[DATA_BITS-1:0])) != shift_q[DATA_BITS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rx_tick_i) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              tick_q  <= '0;
            end
          end
          START: begin
            tick_q <= tick_q + TICK_ONE;
            // Re-check the line half a bit after the edge to reject glitches.
            if (tick_q == TICK_MID) begin
              if (!rx_s) begin
                state_q <= DATA;
                tick_q  <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          DATA: begin
            // The tick counter wraps to zero on the sample tick by itself.
            tick_q <= tick_q + TICK_ONE;
            if (tick_q == TICK_END) begin
              shift_q <= shift_d;
              bit_q   <= bit_q + 4'd1;
              if (bit_q == LAST_BIT) begin
                state_q <= STOP;
                tick_q  <= '0;
              end
            end
          end
          STOP: begin
            tick_q <= tick_q + TICK_ONE;
            // Sampling mid stop bit and returning to IDLE right away leaves
            // half a bit to catch a back-to-back start edge.
            if (tick_q == TICK_END) begin
              data_q       <= shift_q[DATA_BITS-1:0];
              parity_err_q <= parity_err_d;
              frame_err_q  <= !rx_s;
              rx_valid_q   <= 1'b1;
              state_q      <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out_o   = data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign rx_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. A line driver serialises frames
// (start, data LSB first, parity bit, stop bit) timed in rx_tick strobes.
// Expected results are derived from the frame contents alone: data as sent,
// parity error when the sent parity bit differs from the XOR of the data,
// framing error when the sent stop bit is 0. A monitor matches every
// rx_valid pulse against a queue of expected results.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TICK_DIV = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_tick = 1'b0;
  logic [DB-1:0] data_out;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  typedef struct {
    logic [7:0] data;      // data bits driven on the line
    logic       par;       // parity bit driven on the line
    logic       stop;      // stop bit driven on the line
    int         gap_bits;  // idle-high bit periods before the frame
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  rec_t exp_q[$];
  vec_t tbl[7];

  uart_rx #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .rx_tick_i   (rx_tick),
    .data_out_o  (data_out),
    .rx_valid_o  (rx_valid),
    .parity_err_o(parity_err),
    .frame_err_o (frame_err),
    .rx_busy_o   (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      rx_tick = (cnt == TICK_DIV - 1);
      cnt = (cnt + 1) % TICK_DIV;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse must match the oldest expected frame and
  // last exactly one clock.
  initial begin : monitor
    logic prev_v;
    rec_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        check("valid_one_cycle", 32'(prev_v), 32'd0);
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got data 0x%0h, required no frame", data_out);
          end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            check("frame_err", 32'(frame_err), 32'(e.ferr));
            $display("frame: data=0x%02h perr=%0d ferr=%0d (expected 0x%02h %0d %0d)",
                     data_out, parity_err, frame_err, e.data, e.perr, e.ferr);
          end
        end
      end
      prev_v = rx_valid;
    end
  end

  // Wait for n rx_tick strobes, then step 1 time unit off the edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_ticks(n * OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = p;
    wait_ticks(OS);
    rx = s;
    wait_ticks(OS);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    rec_t r;
    r.data = d;
    r.perr = perr;
    r.ferr = ferr;
    exp_q.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin : main
    logic       seen_busy;
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       prev_stop;
    int         gap;
    int         k;

    // Directed frames: A5 clean, 01 bad parity, 3C bad stop then 55 clean,
    // then 00/FF/80 back-to-back with a single stop bit.
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 2, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h55, 1'b0, 1'b1, 2, 8'h55, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 2, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 0, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 1'b1, 1'b1, 0, 8'h80, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      expect_frame(tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
      idle_bits(tbl[i].gap_bits);
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
    end
    idle_bits(2);
    check("table_frames_pending", 32'(exp_q.size()), 32'd0);

    // Glitch: line low for 4 ticks only.
    seen_busy = 1'b0;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    for (int c = 0; c < 2 * OS * TICK_DIV; c++) begin
      @(negedge clk);
      if (rx_busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen_busy), 32'd1);
    check("glitch_busy_cleared", 32'(rx_busy), 32'd0);
    check("glitch_data_held", 32'(data_out), 32'h80);
    #1;

    // Reset for one clock in the middle of data bit 4.
    d = 8'h3A;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    rx = d[4];
    wait_ticks(OS / 2);
    @(negedge clk);
    check("abort_busy_before_reset", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b1;
    #1;
    idle_bits(3);
    check("abort_no_busy", 32'(rx_busy), 32'd0);
    check("abort_data_still_reset", 32'(data_out), 32'd0);
    expect_frame(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1);
    idle_bits(2);
    check("after_abort_pending", 32'(exp_q.size()), 32'd0);

    // Randomised frames with occasional parity and stop-bit errors.
    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      // After a low stop bit the receiver re-arms on the still-low line, so
      // the line must return high before the next start edge.
      gap = $urandom_range(0, 2) + (prev_stop ? 0 : 1);
      expect_frame(d, p != (^d), !s);
      idle_bits(gap);
      k = $urandom_range(0, 2);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
      send_frame(d, p, s);
      prev_stop = s;
    end
    idle_bits(3);
    check("random_frames_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
